// File: rtl/display_capture.sv
// Passive monitor for the multiplexed 7-segment lock display: debounces each scanned
// digit, assembles four-digit frames and reports locked / unlocked / stalled status.
module display_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  enable,
    input  logic [7:0]  toDisplay,
    output logic [11:0] digits,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        is_locked,
    output logic        is_unlocked,
    output logic        stalled
);
    typedef enum logic [2:0] {
        SYM_A   = 3'd0,
        SYM_B   = 3'd1,
        SYM_C   = 3'd2,
        SYM_L   = 3'd3,
        SYM_U   = 3'd4,
        SYM_OFF = 3'd5,
        SYM_BAD = 3'd7
    } sym_e;

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STABLE_PRE  = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_PRE = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0] ALL_OFF     = {SYM_OFF, SYM_OFF, SYM_OFF, SYM_OFF};
    localparam logic [11:0] ALL_L       = {SYM_L, SYM_L, SYM_L, SYM_L};
    localparam logic [11:0] ALL_U       = {SYM_U, SYM_U, SYM_U, SYM_U};

    function automatic sym_e decode(input logic [7:0] seg);
        case (seg)
            8'h88:   decode = SYM_A;
            8'h83:   decode = SYM_B;
            8'hC6:   decode = SYM_C;
            8'hC7:   decode = SYM_L;
            8'hC1:   decode = SYM_U;
            8'hFF:   decode = SYM_OFF;
            default: decode = SYM_BAD;
        endcase
    endfunction

    logic [11:0] s_q, s_d, s_prev_q, s_prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  seen_q, seen_d;
    logic        bad_q, bad_d;
    logic [11:0] shadow_q, shadow_d;
    logic [23:0] idle_q, idle_d;
    logic [11:0] digits_q, digits_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        is_locked_q, is_locked_d;
    logic        is_unlocked_q, is_unlocked_d;
    logic        stalled_q, stalled_d;

    logic        capture;
    logic        legal;
    logic        blank;
    logic [1:0]  sel_idx;
    sym_e        code;

    // A capture fires exactly once per stable run: on the cnt step into saturation.
    assign capture = (s_q == s_prev_q) && (cnt_q == STABLE_PRE);
    assign legal   = $onehot(~s_q[11:8]);
    assign blank   = &s_q[11:8];
    assign code    = decode(s_q[7:0]);

    always_comb begin
        sel_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!s_q[8 + k]) sel_idx = 2'(k);
        end
    end

    always_comb begin
        // NOTE: every _d takes a default first, so no path through this block can infer a latch.
        s_d           = {enable, toDisplay};
        s_prev_d      = s_q;
        cnt_d         = '0;
        seen_d        = seen_q;
        bad_d         = bad_q;
        shadow_d      = shadow_q;
        idle_d        = (idle_q == '1) ? idle_q : idle_q + 24'd1;
        digits_d      = digits_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        is_locked_d   = is_locked_q;
        is_unlocked_d = is_unlocked_q;
        stalled_d     = stalled_q;

        if (s_q == s_prev_q) begin
            cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
        end

        if (capture && (legal || blank)) begin
            idle_d = '0;
        end else if (idle_q == TIMEOUT_PRE) begin
            stalled_d = 1'b1;
            seen_d    = '0;
            bad_d     = 1'b0;
        end

        if (capture && legal) begin
            for (int k = 0; k < 4; k++) begin
                if (sel_idx == 2'(k)) shadow_d[3*k +: 3] = code;
            end
            seen_d    = seen_q | (4'b0001 << sel_idx);
            bad_d     = bad_q | (code == SYM_BAD);
            stalled_d = 1'b0;
            if (seen_d == 4'hF) begin
                digits_d      = shadow_d;
                frame_valid_d = 1'b1;
                frame_err_d   = bad_d;
                is_locked_d   = (shadow_d == ALL_L);
                is_unlocked_d = (shadow_d == ALL_U);
                seen_d        = '0;
                bad_d         = 1'b0;
            end
        end else if (capture && !blank) begin
            bad_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments; reset is synchronous.
        if (rst) begin
            s_q           <= 12'hFFF;
            s_prev_q      <= 12'hFFF;
            cnt_q         <= '0;
            seen_q        <= '0;
            bad_q         <= 1'b0;
            shadow_q      <= ALL_OFF;
            idle_q        <= '0;
            digits_q      <= ALL_OFF;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            is_locked_q   <= 1'b0;
            is_unlocked_q <= 1'b0;
            stalled_q     <= 1'b0;
        end else begin
            s_q           <= s_d;
            s_prev_q      <= s_prev_d;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            bad_q         <= bad_d;
            shadow_q      <= shadow_d;
            idle_q        <= idle_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            is_locked_q   <= is_locked_d;
            is_unlocked_q <= is_unlocked_d;
            stalled_q     <= stalled_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign is_locked   = is_locked_q;
    assign is_unlocked = is_unlocked_q;
    assign stalled     = stalled_q;
endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: random scanned-digit traffic compared
// against a frame-level behavioural model of the display monitor.
`timescale 1ns/1ps
module tb_display_capture;
    localparam int STABLE   = 4;
    localparam int TIMEOUT  = 16;
    localparam int CAP_EDGE = STABLE + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enable;
    logic [7:0]  to_display;
    logic [11:0] digits;
    logic        frame_valid;
    logic        frame_err;
    logic        is_locked;
    logic        is_unlocked;
    logic        stalled;

    display_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .toDisplay   (to_display),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .is_locked   (is_locked),
        .is_unlocked (is_unlocked),
        .stalled     (stalled)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: the display as four digit slots and a frame counter.
    int          m_shadow [4];
    bit          m_seen   [4];
    int          m_digits [4];
    bit          m_bad;
    int          m_frames = 0;
    bit          m_last_fe;
    bit          m_locked, m_unlocked, m_stalled;
    int          m_idle;

    int          obs_frames = 0;
    bit          obs_last_fe = 1'b0;
    int          obs_stray = 0;
    logic [11:0] last_word = 12'hFFF;

    localparam logic [7:0] SEG_TABLE [6] = '{8'h88, 8'h83, 8'hC6, 8'hC7, 8'hC1, 8'hFF};

    function automatic int sym_of(input logic [7:0] seg);
        int r;
        r = 7;
        for (int i = 0; i < 6; i++) if (SEG_TABLE[i] == seg) r = i;
        return r;
    endfunction

    function automatic logic [11:0] exp_digits();
        return {3'(m_digits[3]), 3'(m_digits[2]), 3'(m_digits[1]), 3'(m_digits[0])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 5;
            m_digits[i] = 5;
            m_seen[i]   = 1'b0;
        end
        m_bad = 0; m_locked = 0; m_unlocked = 0; m_stalled = 0; m_idle = 0;
    endtask

    task automatic model_edge(input logic [11:0] w, input bit cap);
        int  lows;
        int  k;
        bit  all_seen, all_l, all_u;
        lows = 0;
        k    = 0;
        if (cap) for (int i = 0; i < 4; i++) if (!w[8 + i]) begin lows++; k = i; end
        if (cap && lows <= 1) begin
            m_idle = 0;
        end else begin
            if (m_idle < 24'hFFFFFF) m_idle++;
            if (m_idle == TIMEOUT) begin
                m_stalled = 1;
                m_bad     = 0;
                for (int i = 0; i < 4; i++) m_seen[i] = 0;
            end
        end
        if (cap && lows == 1) begin
            m_shadow[k] = sym_of(w[7:0]);
            m_seen[k]   = 1;
            if (m_shadow[k] == 7) m_bad = 1;
            m_stalled = 0;
            all_seen = 1; all_l = 1; all_u = 1;
            for (int i = 0; i < 4; i++) begin
                all_seen &= m_seen[i];
                all_l    &= (m_shadow[i] == 3);
                all_u    &= (m_shadow[i] == 4);
            end
            if (all_seen) begin
                for (int i = 0; i < 4; i++) begin
                    m_digits[i] = m_shadow[i];
                    m_seen[i]   = 0;
                end
                m_frames++;
                m_last_fe  = m_bad;
                m_locked   = all_l;
                m_unlocked = all_u;
                m_bad      = 0;
            end
        end else if (cap && lows > 1) begin
            m_bad = 1;
        end
    endtask

    task automatic observe();
        if (frame_valid) begin
            obs_frames++;
            obs_last_fe = frame_err;
        end else if (frame_err) begin
            obs_stray++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 4'hF; to_display = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        last_word = 12'hFFF;
    endtask

    task automatic drive_seg(input logic [3:0] en, input logic [7:0] seg, input int hold);
        logic [11:0] w;
        w = {en, seg};
        if (w == last_word) w[0] = ~w[0];
        enable = w[11:8]; to_display = w[7:0]; last_word = w;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            model_edge(w, i == CAP_EDGE);
            observe();
        end
    endtask

    task automatic send_digit(input int k, input logic [7:0] seg, input int hold);
        drive_seg(~(4'b0001 << k), seg, hold);
    endtask

    function automatic int rhold();
        return 8 + int'($urandom % 5);
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++; if (digits !== exp_digits()) begin miscompares++; $display("FAIL reset_digits: got %h expected %h", digits, exp_digits()); end
        vectors++; if ({frame_valid, frame_err, is_locked, is_unlocked, stalled} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 00000", {frame_valid, frame_err, is_locked, is_unlocked, stalled}); end
    endtask

    task automatic test_lock();
        for (int k = 0; k < 4; k++) send_digit(k, 8'hC7, rhold());
        vectors++; if (obs_frames !== m_frames) begin miscompares++; $display("FAIL lock_frames: got %0d expected %0d", obs_frames, m_frames); end
        vectors++; if (digits !== exp_digits()) begin miscompares++; $display("FAIL lock_digits: got %h expected %h", digits, exp_digits()); end
        vectors++; if (is_locked !== m_locked || is_unlocked !== m_unlocked) begin
            miscompares++; $display("FAIL lock_status: got %b%b expected %b%b", is_locked, is_unlocked, m_locked, m_unlocked); end
        vectors++; if (obs_last_fe !== m_last_fe) begin miscompares++; $display("FAIL lock_err: got %b expected %b", obs_last_fe, m_last_fe); end
    endtask

    task automatic test_glitch();
        send_digit(0, 8'hC1, rhold());
        send_digit(1, 8'hC1, rhold());
        send_digit(2, 8'hC1, 7);
        send_digit(2, 8'h00, 3);
        send_digit(2, 8'hC1, 7);
        send_digit(3, 8'h00, 1);
        send_digit(3, 8'hC1, rhold());
        vectors++; if (obs_frames !== m_frames) begin miscompares++; $display("FAIL glitch_frames: got %0d expected %0d", obs_frames, m_frames); end
        vectors++; if (digits !== exp_digits()) begin miscompares++; $display("FAIL glitch_digits: got %h expected %h", digits, exp_digits()); end
        vectors++; if (is_unlocked !== m_unlocked || is_locked !== m_locked) begin
            miscompares++; $display("FAIL glitch_status: got %b%b expected %b%b", is_locked, is_unlocked, m_locked, m_unlocked); end
        vectors++; if (obs_last_fe !== m_last_fe) begin miscompares++; $display("FAIL glitch_err: got %b expected %b", obs_last_fe, m_last_fe); end
    endtask

    task automatic test_mixed();
        send_digit(3, 8'h88, rhold());
        send_digit(2, 8'h83, rhold());
        send_digit(1, 8'hFF, rhold());
        send_digit(0, 8'hFF, rhold());
        vectors++; if (digits !== exp_digits()) begin miscompares++; $display("FAIL mixed_digits: got %h expected %h", digits, exp_digits()); end
        vectors++; if (is_locked !== m_locked || is_unlocked !== m_unlocked) begin
            miscompares++; $display("FAIL mixed_status: got %b%b expected %b%b", is_locked, is_unlocked, m_locked, m_unlocked); end
    endtask

    task automatic test_error();
        send_digit(0, 8'hC6, rhold());
        send_digit(1, 8'h12, rhold());
        send_digit(2, 8'h88, rhold());
        send_digit(3, 8'h83, rhold());
        vectors++; if (obs_last_fe !== m_last_fe || obs_frames !== m_frames) begin
            miscompares++; $display("FAIL err_badseg: got fe=%b n=%0d expected fe=%b n=%0d", obs_last_fe, obs_frames, m_last_fe, m_frames); end
        for (int k = 0; k < 4; k++) send_digit(k, 8'hC7, rhold());
        vectors++; if (obs_last_fe !== m_last_fe) begin miscompares++; $display("FAIL err_clean1: got %b expected %b", obs_last_fe, m_last_fe); end
        send_digit(0, 8'hC1, 6);
        drive_seg(4'b0011, 8'hC1, 6);
        for (int k = 1; k < 4; k++) send_digit(k, 8'hC1, 6 + int'($urandom % 3));
        vectors++; if (obs_last_fe !== m_last_fe || obs_frames !== m_frames) begin
            miscompares++; $display("FAIL err_multilow: got fe=%b n=%0d expected fe=%b n=%0d", obs_last_fe, obs_frames, m_last_fe, m_frames); end
        for (int k = 0; k < 4; k++) send_digit(k, 8'h88, rhold());
        vectors++; if (obs_last_fe !== m_last_fe) begin miscompares++; $display("FAIL err_clean2: got %b expected %b", obs_last_fe, m_last_fe); end
    endtask

    task automatic test_back_to_back();
        int          order [4];
        int          kind, j, t;
        logic [7:0]  seg;
        for (int f = 0; f < 10; f++) begin
            kind = int'($urandom % 4);
            for (int i = 0; i < 4; i++) order[i] = i;
            for (int i = 3; i > 0; i--) begin
                j = int'($urandom % (i + 1)); t = order[i]; order[i] = order[j]; order[j] = t;
            end
            for (int i = 0; i < 4; i++) begin
                if (kind == 0)      seg = 8'hC7;
                else if (kind == 1) seg = 8'hC1;
                else if (($urandom % 8) == 0) seg = 8'($urandom);
                else seg = SEG_TABLE[$urandom % 6];
                if (($urandom % 4) == 0) send_digit(order[i], 8'($urandom), 1 + int'($urandom % 3));
                if (($urandom % 6) == 0) send_digit(order[i], SEG_TABLE[$urandom % 6], 6);
                send_digit(order[i], seg, 6 + int'($urandom % 7));
            end
            vectors++; if (obs_frames !== m_frames || digits !== exp_digits()) begin
                miscompares++; $display("FAIL b2b_frame%0d: got n=%0d d=%h expected n=%0d d=%h", f, obs_frames, digits, m_frames, exp_digits()); end
            vectors++; if (obs_last_fe !== m_last_fe || is_locked !== m_locked || is_unlocked !== m_unlocked) begin
                miscompares++; $display("FAIL b2b_flags%0d: got %b%b%b expected %b%b%b", f, obs_last_fe, is_locked, is_unlocked, m_last_fe, m_locked, m_unlocked); end
        end
    endtask

    task automatic test_stall();
        logic [11:0] held;
        send_digit(0, 8'hC7, 8);
        send_digit(1, 8'hC7, 8);
        held = digits;
        enable = 4'hF; to_display = 8'hFF; last_word = 12'hFFF;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            model_edge(12'hFFF, i == CAP_EDGE);
            observe();
            vectors++; if (stalled !== m_stalled) begin
                miscompares++; $display("FAIL stall_edge%0d: got %b expected %b", i, stalled, m_stalled); end
        end
        vectors++; if (digits !== exp_digits() || digits !== held) begin
            miscompares++; $display("FAIL stall_digits: got %h expected %h", digits, exp_digits()); end
        send_digit(2, 8'hC7, 8);
        vectors++; if (stalled !== m_stalled) begin miscompares++; $display("FAIL stall_clear: got %b expected %b", stalled, m_stalled); end
        send_digit(3, 8'hC7, 8);
        vectors++; if (obs_frames !== m_frames) begin miscompares++; $display("FAIL stall_seen: got %0d expected %0d", obs_frames, m_frames); end
        send_digit(0, 8'hC7, 8);
        send_digit(1, 8'hC7, 8);
        vectors++; if (obs_frames !== m_frames || digits !== exp_digits()) begin
            miscompares++; $display("FAIL stall_refill: got n=%0d d=%h expected n=%0d d=%h", obs_frames, digits, m_frames, exp_digits()); end
    endtask

    task automatic test_reset_mid();
        send_digit(0, 8'hC6, 8);
        send_digit(1, 8'hC6, 8);
        do_reset();
        vectors++; if (digits !== exp_digits() || is_locked !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_state: got %h expected %h", digits, exp_digits()); end
        send_digit(2, 8'h83, 8);
        send_digit(3, 8'h88, 8);
        vectors++; if (obs_frames !== m_frames) begin miscompares++; $display("FAIL rstmid_partial: got %0d expected %0d", obs_frames, m_frames); end
        send_digit(0, 8'hC1, 8);
        send_digit(1, 8'hC7, 8);
        vectors++; if (obs_frames !== m_frames || digits !== exp_digits()) begin
            miscompares++; $display("FAIL rstmid_frame: got n=%0d d=%h expected n=%0d d=%h", obs_frames, digits, m_frames, exp_digits()); end
    endtask

    initial begin
        rst = 1'b1; enable = 4'hF; to_display = 8'hFF;
        model_reset();
        test_reset();
        test_lock();
        test_glitch();
        test_mixed();
        test_error();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        vectors++; if (obs_stray !== 0) begin miscompares++; $display("FAIL stray_frame_err: got %0d expected 0", obs_stray); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
